// File: rtl/qpsk_dibit_uart_tx.sv
// QPSK dibit packer, byte FIFO and UART transmitter (8N1, LSB first).
// Define UART_PARITY_EN for 8E1 framing with an even parity bit.
module qpsk_dibit_uart_tx #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [1:0]                  bit_in,
  input  logic                        bit_valid,
  input  logic                        symbol_lock,
  input  logic                        flush,
  input  logic                        clear_ovf,
  output logic                        uart_txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int CPB = CLK_FREQ_HZ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = AW + 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(CPB - 1);
  localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd4;
`endif

  logic [1:0]    idx;
  logic [7:0]    pk;
  logic          lock_q;
  logic          accept;
  logic          lock_fall;
  logic          full_a;
  logic          push;
  logic [1:0]    idx_a;
  logic [7:0]    pk_a;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [NW-1:0] count;
  logic          fifo_full;
  logic          pop;
  logic          wr_en;
  logic          ovf_set;

  logic [2:0]    state;
  logic [2:0]    state_d;
  logic [CW-1:0] baud;
  logic          tick;
  logic [2:0]    bitn;
  logic [2:0]    bitn_d;
  logic [7:0]    sh;
  logic [7:0]    sh_d;
  logic          txd_q;
  logic          txd_d;
`ifdef UART_PARITY_EN
  logic          par;
  logic          par_d;
`endif

  // The dibit is merged before flush is considered, so a flush that
  // coincides with the completing dibit still yields a single push.
  always_comb begin
    accept    = bit_valid & symbol_lock;
    lock_fall = lock_q & ~symbol_lock;
    idx_a     = idx;
    pk_a      = pk;
    if (accept) begin
      unique case (idx)
        2'd0: pk_a = {bit_in, 6'b0};
        2'd1: pk_a[5:4] = bit_in;
        2'd2: pk_a[3:2] = bit_in;
        2'd3: pk_a[1:0] = bit_in;
      endcase
      idx_a = idx + 2'd1;
    end
    full_a = accept && (idx == 2'd3);
    push   = !lock_fall &&
             (full_a || (flush && (idx_a != 2'd0)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx    <= 2'd0;
      pk     <= 8'h00;
      lock_q <= 1'b0;
    end else begin
      lock_q <= symbol_lock;
      if (lock_fall || push) begin
        idx <= 2'd0;
        pk  <= 8'h00;
      end else begin
        idx <= idx_a;
        pk  <= pk_a;
      end
    end
  end

  assign fifo_full = (count == FULL_CNT);
  assign pop       = (state == S_IDLE) && (count != '0);
  assign wr_en     = push && (!fifo_full || pop);
  assign ovf_set   = push && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= pk_a;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
      if (ovf_set)
        overflow <= 1'b1;
      else if (clear_ovf)
        overflow <= 1'b0;
    end
  end

  assign fifo_count = count;

  assign tick = (baud == CNT_MAX);

  always_comb begin
    state_d = state;
    sh_d    = sh;
    bitn_d  = bitn;
`ifdef UART_PARITY_EN
    par_d   = par;
`endif
    case (state)
      S_IDLE: begin
        if (pop) begin
          state_d = S_START;
          sh_d    = mem[rd_ptr];
          bitn_d  = 3'd0;
`ifdef UART_PARITY_EN
          par_d   = ^mem[rd_ptr];
`endif
        end
      end
      S_START: begin
        if (tick)
          state_d = S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          if (bitn == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end else begin
            sh_d   = {1'b0, sh[7:1]};
            bitn_d = bitn + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: begin
        if (tick)
          state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the next state so txd is a clean register.
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = sh_d[0];
`ifdef UART_PARITY_EN
      S_PAR:   txd_d = par_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      baud  <= '0;
      bitn  <= 3'd0;
      sh    <= 8'h00;
      txd_q <= 1'b1;
`ifdef UART_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_d;
      sh    <= sh_d;
      bitn  <= bitn_d;
      txd_q <= txd_d;
`ifdef UART_PARITY_EN
      par   <= par_d;
`endif
      if ((state == S_IDLE) || tick)
        baud <= '0;
      else
        baud <= baud + CW'(1);
    end
  end

  assign uart_txd = txd_q;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_qpsk_dibit_uart_tx.sv
// Bench for qpsk_dibit_uart_tx: vector table, UART line monitor
// and expected-byte scoreboard (10 clks per bit).
module tb_qpsk_dibit_uart_tx;

  localparam int CPB = 10;
`ifdef UART_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       clk;
  logic       reset_n;
  logic [1:0] bit_in;
  logic       bit_valid;
  logic       symbol_lock;
  logic       flush;
  logic       clear_ovf;
  logic       uart_txd;
  logic       busy;
  logic [4:0] fifo_count;
  logic       overflow;

  qpsk_dibit_uart_tx #(
    .CLK_FREQ_HZ(1000),
    .BAUD(100),
    .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bit_in(bit_in),
    .bit_valid(bit_valid),
    .symbol_lock(symbol_lock),
    .flush(flush),
    .clear_ovf(clear_ovf),
    .uart_txd(uart_txd),
    .busy(busy),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int peak     = 0;
  logic [7:0] sb [$];
  int starts [$];
  bit log_gaps = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (int'(fifo_count) > peak) peak <= int'(fifo_count);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic bit_at(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // UART line monitor: every frame is checked sample-by-sample.
  logic [7:0] m_exp, m_rx;
  logic m_ok, m_had, m_abort, m_eb, m_ebusy;
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && uart_txd == 1'b0) begin
        if (log_gaps) starts.push_back(cyc);
        m_had = (sb.size() != 0);
        chk("frame expected", m_had, 1);
        m_exp = m_had ? sb.pop_front() : 8'h00;
        m_ok = 1'b1;
        m_rx = 8'h00;
        m_abort = 1'b0;
        for (int p = 0; p <= FRAME; p++) begin
          if (p > 0) @(negedge clk);
          if (!reset_n) begin
            m_abort = 1'b1;
            break;
          end
          m_eb    = (p == FRAME) ? 1'b1 : bit_at(m_exp, p / CPB);
          m_ebusy = (p != FRAME);
          if (uart_txd !== m_eb || busy !== m_ebusy) m_ok = 1'b0;
          if (p / CPB >= 1 && p / CPB <= 8 && p % CPB == CPB / 2)
            m_rx[p / CPB - 1] = uart_txd;
        end
        if (!m_abort) begin
          chk("frame shape", m_ok, 1);
          chk("frame byte", m_rx, m_exp);
        end
      end
    end
  end

  task automatic cyc_in(input logic [1:0] d, input logic v,
                        input logic f);
    bit_in = d;
    bit_valid = v;
    flush = f;
    @(negedge clk);
    bit_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) cyc_in(b[7-2*k -: 2], 1'b1, 1'b0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy || fifo_count != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " drain"}, n < 4000, 1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] dib;
    int         n;
    int         mode;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [7:0] t;
    logic [7:0] b;
    int n;
    bit gap_ok;

    vecs[0] = '{8'h55, 4, 0, 8'h55};
    vecs[1] = '{8'hC0, 1, 1, 8'hC0};
    vecs[2] = '{8'h90, 2, 1, 8'h90};
    vecs[3] = '{8'hFC, 3, 1, 8'hFC};
    vecs[4] = '{8'h03, 4, 2, 8'h03};
    vecs[5] = '{8'hC0, 1, 2, 8'hC0};
    vecs[6] = '{8'h01, 4, 0, 8'h01};
    vecs[7] = '{8'hA5, 4, 0, 8'hA5};
    vecs[8] = '{8'hE4, 4, 0, 8'hE4};

    reset_n = 1'b0;
    bit_in = 2'b00;
    bit_valid = 1'b0;
    symbol_lock = 1'b0;
    flush = 1'b0;
    clear_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset txd", uart_txd, 1);
    chk("reset busy", busy, 0);
    chk("reset count", fifo_count, 0);
    chk("reset ovf", overflow, 0);
    reset_n = 1'b1;
    symbol_lock = 1'b1;
    @(negedge clk);

    // 00,01,10,11 -> 0x1B, push latency and immediate pop
    sb.push_back(8'h1B);
    cyc_in(2'b00, 1, 0);
    cyc_in(2'b01, 1, 0);
    cyc_in(2'b10, 1, 0);
    cyc_in(2'b11, 1, 0);
    chk("push latency count", fifo_count, 1);
    @(negedge clk);
    chk("pop count", fifo_count, 0);
    chk("busy after pop", busy, 1);
    drain("t1");

    for (int i = 0; i < 9; i++) begin
      t = vecs[i].dib;
      sb.push_back(vecs[i].exp);
      for (int k = 0; k < vecs[i].n; k++)
        cyc_in(t[7-2*k -: 2], 1,
               (vecs[i].mode == 2) && (k == vecs[i].n - 1));
      cyc_in(2'b00, 0, 0);
      if (vecs[i].mode == 1) cyc_in(2'b00, 0, 1);
      drain("vec");
    end

    // flush with an empty packer produces nothing
    cyc_in(2'b00, 0, 1);
    repeat (20) @(negedge clk);
    chk("empty flush count", fifo_count, 0);
    chk("empty flush busy", busy, 0);

    // partial byte discarded on lock loss
    sb.push_back(8'h55);
    cyc_in(2'b11, 1, 0);
    cyc_in(2'b10, 1, 0);
    cyc_in(2'b00, 0, 0);
    symbol_lock = 1'b0;
    cyc_in(2'b11, 1, 0);
    cyc_in(2'b00, 0, 0);
    chk("lock drop count", fifo_count, 0);
    chk("lock drop busy", busy, 0);
    symbol_lock = 1'b1;
    cyc_in(2'b00, 0, 0);
    repeat (4) cyc_in(2'b01, 1, 0);
    drain("lock");

    // overflow while frame 1 is on the line
    starts.delete();
    log_gaps = 1;
    for (int i = 0; i < 18; i++) begin
      b = 8'(i * 37 + 5);
      if (i < 17) sb.push_back(b);
      send_byte(b);
    end
    chk("full count", fifo_count, 16);
    chk("ovf set", overflow, 1);
    chk("peak count", peak, 16);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    chk("ovf cleared", overflow, 0);
    cyc_in(2'b10, 1, 0);
    cyc_in(2'b01, 1, 0);
    cyc_in(2'b10, 1, 0);
    clear_ovf = 1'b1;
    cyc_in(2'b01, 1, 0);
    clear_ovf = 1'b0;
    chk("ovf wins clear", overflow, 1);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    chk("ovf cleared 2", overflow, 0);
    sb.push_back(8'h3C);
    cyc_in(2'b00, 1, 0);
    cyc_in(2'b11, 1, 0);
    cyc_in(2'b11, 1, 0);
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("stall end wait", n < 300, 1);
    cyc_in(2'b00, 1, 0);
    chk("push+pop full count", fifo_count, 16);
    chk("push+pop no ovf", overflow, 0);
    drain("burst");
    log_gaps = 0;
    chk("burst frames", starts.size(), 18);
    gap_ok = 1'b1;
    for (int i = 0; i + 1 < starts.size(); i++)
      if (starts[i+1] - starts[i] != FRAME + 1) gap_ok = 1'b0;
    chk("frame gap", gap_ok, 1);

    // reset in the middle of DATA
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (30) @(negedge clk);
    chk("pre reset count", fifo_count, 1);
    chk("pre reset busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async txd", uart_txd, 1);
    chk("async busy", busy, 0);
    chk("async count", fifo_count, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    sb.push_back(8'hA5);
    send_byte(8'hA5);
    drain("post reset");

    repeat (FRAME + 5) @(negedge clk);
    chk("final sb empty", sb.size(), 0);
    chk("final count", fifo_count, 0);
    chk("final ovf", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/qpsk_dibit_uart_tx.md
Name: qpsk_dibit_uart_tx

Overview:
Downstream stage of the QPSK demodulator: takes its dibit output (bit_out/bit_valid) while symbol_lock is high and packs four dibits into a byte. Bytes are buffered in a small FIFO and serialised on the board UART TX pin (8N1, LSB first), replacing the currently idle uart_txd. Runs entirely in the 100 MHz domain; there are no other clocks.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency
BAUD, 115200, UART bit rate; clocks per bit = CLK_FREQ_HZ/BAUD, integer-truncated, must be >= 2
FIFO_DEPTH, 16, byte FIFO depth; power of two, >= 2

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  reset, asynchronous assert, active-low; deassertion pre-synchronised by the top level
bit_in  in  2  demodulated dibit (demodulator bit_out)
bit_valid  in  1  bit_in qualifier, single-cycle pulses
symbol_lock  in  1  demodulator lock; dibits are accepted only while high
flush  in  1  pulse: pad the partial byte with zeros and push it
clear_ovf  in  1  pulse: clear overflow
uart_txd  out  1  serial output, idle high
busy  out  1  high while a frame is being shifted out
fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes held in the FIFO
overflow  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (reset_n=0, async): uart_txd=1, busy=0, fifo_count=0, overflow=0. The packer, FIFO pointers, baud counter and FSM all clear.
- Packer: 2-bit dibit index idx plus an 8-bit shift register.
- On bit_valid&&symbol_lock, the dibit is placed at byte[7-2*idx -: 2], so the first dibit lands in [7:6], and idx increments.
- When the 4th dibit is taken (idx 3->0), the byte is pushed on the next cycle. Latency from the 4th bit_valid to fifo_count increment is 1 clk.
- bit_valid with symbol_lock=0: the dibit is ignored.
- symbol_lock falling (registered 1->0): the partial byte is discarded and idx=0.
- flush with idx!=0: remaining dibits are filled with 00, the byte is pushed, idx=0. flush with idx==0: no action.
- flush in the same cycle as an accepted bit_valid: the dibit is included first, then the flush applies. If that dibit completes the byte, only one push occurs.
- FIFO: synchronous, first-word-fall-through to the TX FSM. Pointers are log2(FIFO_DEPTH) bits and wrap naturally; fifo_count tracks occupancy from 0 to FIFO_DEPTH.
- Push when fifo_count==FIFO_DEPTH with no pop in the same cycle: the byte is dropped and overflow is set on the next clk.
- Push and pop in the same cycle: both take effect and fifo_count is unchanged, including when the FIFO is full.
- clear_ovf and a new overflow in the same cycle: overflow stays 1.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is held at 0 in IDLE, so the first start-bit edge is aligned to the pop.
- TX FSM states: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
- IDLE: uart_txd=1, busy=0. If the FIFO is not empty, pop, load the shifter and go to START on the next clk.
- START: uart_txd=0 for CLKS_PER_BIT clks.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT clks, with a 3-bit bit counter.
- STOP: uart_txd=1 for CLKS_PER_BIT clks, then IDLE.
- busy=1 in all states except IDLE. Back-to-back frames add exactly 1 idle clk (STOP -> IDLE -> pop).
- Frame length is 10*CLKS_PER_BIT clks, or 11*CLKS_PER_BIT with parity.
- Reset mid-frame: uart_txd returns to 1 immediately (async) and the frame is lost.

Optional Feature:
UART_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It sends even parity (XOR of the 8 data bits) for CLKS_PER_BIT clks, giving 8E1 framing.
- Undefined: no PARITY state, 8N1 framing, no parity logic synthesised.

Test Plan:
1. Bench parameters: CLK_FREQ_HZ=1000, BAUD=100 (10 clks/bit). Stimulus: symbol_lock=1, dibits 00,01,10,11. Required response: one push of 0x1B; uart_txd is low for 10 clks, then bits 1,1,0,1,1,0,0,0, then high for 10 clks; busy=1 for 100 clks.
2. Accept dibits 11,10, drop symbol_lock to 0, then raise it and send 01,01,01,01. Required response: only 0x55 is transmitted.
3. Send dibit 11 then pulse flush. Required response: 0xC0 is transmitted. A second flush with idx==0 produces no frame.
4. Push 18 bytes, with the first popped immediately, while the TX is stalled on frame 1. Required response: fifo_count peaks at 16, overflow=1, bytes 18+ are lost. clear_ovf returns overflow to 0. Frames arrive in order with a 1-clk idle gap between them.
5. Assert reset_n=0 mid-DATA. Required response: uart_txd=1, busy=0, fifo_count=0 at once. After release, a new byte 0xA5 transmits cleanly.
6. Build with UART_PARITY_EN and send 0x1B. Required response: parity bit=0 (four ones) and frame length of 110 clks. Byte 0x01 gives parity bit=1.
